// File: rtl/dot_prod_scheduler.sv
// dot_prod_scheduler: round-robin arbiter that streams operand pairs from a shared
// synchronous-read memory into one dot-product engine and returns each job's result.
module dot_prod_scheduler #(
    parameter int NREQ    = 4,
    parameter int AW      = 10,
    parameter int MAX_LEN = 1024
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_base,
    input  logic [NREQ*32-1:0] req_len,
    output logic               mem_rd_en,
    output logic [AW-1:0]      mem_addr,
    input  logic [7:0]         mem_a_data,
    input  logic [7:0]         mem_b_data,
    output logic               eng_start,
    output logic [31:0]        eng_len,
    output logic               eng_valid,
    output logic [7:0]         eng_a,
    output logic [7:0]         eng_b,
    input  logic [31:0]        eng_result,
    input  logic               eng_done,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [31:0]        rsp_data,
    output logic               rsp_err,
    output logic               busy
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, GRANT, START, STREAM, DRAIN, WAIT, RESP} state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q, win_q, win_d;
    logic [AW-1:0]   base_q, addr_q;
    logic [31:0]     len_q, k_q, eng_len_q, rsp_data_q, grant_len;
    logic            rd_en_q, start_q, valid_q, rsp_err_q, busy_q;
    logic [NREQ-1:0] rsp_valid_q;

    // Highest-priority requester is the first set bit at or above the pointer.
    always_comb begin
        win_d = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr_q) + i) % NREQ]) win_d = IW'((int'(ptr_q) + i) % NREQ);
        end
    end

    assign grant_len = req_len[int'(win_q)*32 +: 32];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            k_q         <= '0;
            eng_len_q   <= '0;
            rsp_data_q  <= '0;
            rd_en_q     <= 1'b0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            valid_q <= rd_en_q;
            case (state_q)
                IDLE: if (|req) begin
                    win_q   <= win_d;
                    busy_q  <= 1'b1;
                    state_q <= GRANT;
                end
                GRANT: begin
                    base_q <= req_base[int'(win_q)*AW +: AW];
                    len_q  <= grant_len;
                    ptr_q  <= (int'(win_q) == NREQ - 1) ? '0 : win_q + IW'(1);
                    // Empty and oversized jobs answer directly without touching the engine.
                    if (grant_len == 32'd0 || grant_len > 32'(MAX_LEN)) begin
                        rsp_valid_q <= NREQ'(1) << win_q;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= grant_len != 32'd0;
                        state_q     <= RESP;
                    end else begin
                        start_q   <= 1'b1;
                        eng_len_q <= grant_len;
                        state_q   <= START;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    rd_en_q <= 1'b1;
                    addr_q  <= base_q;
                    k_q     <= 32'd1;
                    state_q <= STREAM;
                end
                STREAM: if (k_q == len_q) begin
                    rd_en_q <= 1'b0;
                    state_q <= DRAIN;
                end else begin
                    addr_q <= base_q + k_q[AW-1:0];
                    k_q    <= k_q + 32'd1;
                end
                DRAIN: state_q <= WAIT;
                WAIT: if (eng_done) begin
                    rsp_valid_q <= NREQ'(1) << win_q;
                    rsp_data_q  <= eng_result;
                    rsp_err_q   <= 1'b0;
                    state_q     <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign eng_start = start_q;
    assign eng_len   = eng_len_q;
    assign eng_valid = valid_q;
    // Memory data arrives the cycle after the read, aligned with the delayed strobe.
    assign eng_a     = valid_q ? mem_a_data : '0;
    assign eng_b     = valid_q ? mem_b_data : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_dot_prod_scheduler.sv
// tb_dot_prod_scheduler: directed bench with a behavioural operand memory and engine
// around dot_prod_scheduler.
module tb_dot_prod_scheduler;
    localparam int NREQ = 4, AW = 10, MAX_LEN = 1024;

    logic clk = 1'b0, rstn = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req = '0;
    logic [NREQ*AW-1:0] req_base = '0;
    logic [NREQ*32-1:0] req_len = '0;
    logic               mem_rd_en;
    logic [AW-1:0]      mem_addr;
    logic signed [7:0]  mem_a_data = '0, mem_b_data = '0;
    logic               eng_start, eng_valid, eng_done;
    logic [31:0]        eng_len, eng_result;
    logic signed [7:0]  eng_a, eng_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_data;
    logic               rsp_err, busy;

    int errors = 0, checks = 0;
    logic signed [7:0] ma [0:1023];
    logic signed [7:0] mb [0:1023];

    dot_prod_scheduler #(.NREQ(NREQ), .AW(AW), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_base(req_base), .req_len(req_len),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_a_data(mem_a_data), .mem_b_data(mem_b_data),
        .eng_start(eng_start), .eng_len(eng_len), .eng_valid(eng_valid), .eng_a(eng_a), .eng_b(eng_b),
        .eng_result(eng_result), .eng_done(eng_done), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    always @(posedge clk) if (mem_rd_en) begin
        mem_a_data <= ma[mem_addr];
        mem_b_data <= mb[mem_addr];
    end

    // Engine: accumulate products, raise done one cycle after the last pair.
    int acc, cnt;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= 0; cnt <= 0; eng_done <= 1'b0; eng_result <= '0;
        end else begin
            eng_done <= 1'b0;
            if (eng_start) begin
                acc <= 0; cnt <= 0;
            end else if (eng_valid) begin
                acc <= acc + int'(eng_a) * int'(eng_b);
                cnt <= cnt + 1;
                if (cnt + 1 == int'(eng_len)) begin
                    eng_done   <= 1'b1;
                    eng_result <= 32'(acc + int'(eng_a) * int'(eng_b));
                end
            end
        end
    end

    int cyc = 0, n_start = 0, n_valid = 0, n_vrise = 0, n_rd = 0, n_rsp = 0, rsp_cyc = 0;
    logic prev_v = 1'b0;
    int addr_log[$];
    int order[$];
    always @(negedge clk) begin
        cyc++;
        if (eng_start) n_start++;
        if (eng_valid) begin
            n_valid++;
            if (!prev_v) n_vrise++;
        end
        prev_v = eng_valid;
        if (mem_rd_en) begin
            n_rd++;
            addr_log.push_back(int'(mem_addr));
        end
        if (rsp_valid != '0) begin
            n_rsp++;
            rsp_cyc = cyc;
            for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) order.push_back(i);
        end
    end

    task automatic set_job(input int idx, input int base, input int len);
        req_base[idx*AW +: AW] = AW'(base);
        req_len[idx*32 +: 32]  = 32'(len);
    endtask

    task automatic wait_rsp(input int base_n, input int budget, input string name);
        int t = 0;
        while (n_rsp == base_n && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        checks++;
        if (n_rsp == base_n) begin
            errors++;
            $display("FAIL %s: no rsp_valid within %0d cycles", name, budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({mem_rd_en, eng_start, eng_valid, busy, rsp_valid, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0", {mem_rd_en, eng_start, eng_valid, busy, rsp_valid, rsp_err});
        end
        checks++;
        if ({mem_addr, eng_len, eng_a, eng_b, rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h len=%0d a=%0d b=%0d data=%0d required all 0", mem_addr, eng_len, eng_a, eng_b, rsp_data);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_single();
        int s_start, s_valid, s_rise, s_rsp, s_addr;
        for (int i = 0; i < 4; i++) begin
            ma[16 + i] = 8'(i + 1);
            mb[16 + i] = 8'(i + 5);
        end
        set_job(0, 'h10, 4);
        s_start = n_start; s_valid = n_valid; s_rise = n_vrise; s_rsp = n_rsp; s_addr = addr_log.size();
        @(posedge clk); #1 req = 4'b0001;
        wait_rsp(s_rsp, 40, "single");
        req = '0;
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 32'd70 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: valid=%b data=%0d err=%b required 0001/70/0", rsp_valid, rsp_data, rsp_err);
        end
        checks++;
        if (n_start - s_start !== 1) begin
            errors++;
            $display("FAIL single_start: got %0d pulses required 1", n_start - s_start);
        end
        checks++;
        if (n_valid - s_valid !== 4 || n_vrise - s_rise !== 1) begin
            errors++;
            $display("FAIL single_stream: valid=%0d bursts=%0d required 4/1", n_valid - s_valid, n_vrise - s_rise);
        end
        checks++;
        if (eng_len !== 32'd4) begin
            errors++;
            $display("FAIL single_len: got %0d required 4", eng_len);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_log.size() <= s_addr + i || addr_log[s_addr + i] !== 16 + i) begin
                errors++;
                $display("FAIL single_addr%0d: got %0d required %0d", i, addr_log.size() > s_addr + i ? addr_log[s_addr + i] : -1, 16 + i);
            end
        end
    endtask

    task automatic test_over();
        int s_start, s_rd, s_rsp;
        set_job(1, 'h100, MAX_LEN + 1);
        s_start = n_start; s_rd = n_rd; s_rsp = n_rsp;
        @(posedge clk); #1 req = 4'b0010;
        wait_rsp(s_rsp, 20, "over");
        req = '0;
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 32'd0 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL over_rsp: valid=%b data=%0d err=%b required 0010/0/1", rsp_valid, rsp_data, rsp_err);
        end
        checks++;
        if (n_start != s_start || n_rd != s_rd) begin
            errors++;
            $display("FAIL over_quiet: starts=%0d reads=%0d required 0/0", n_start - s_start, n_rd - s_rd);
        end
    endtask

    task automatic test_zero();
        int s_start, s_rd, s_rsp, c0;
        set_job(2, 'h0, 0);
        s_start = n_start; s_rd = n_rd; s_rsp = n_rsp;
        @(posedge clk); #1 req = 4'b0100;
        c0 = cyc;
        wait_rsp(s_rsp, 20, "zero");
        req = '0;
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 32'd0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_rsp: valid=%b data=%0d err=%b required 0100/0/0", rsp_valid, rsp_data, rsp_err);
        end
        checks++;
        if (rsp_cyc - c0 > 3) begin
            errors++;
            $display("FAIL zero_latency: got %0d cycles required <= 3", rsp_cyc - c0);
        end
        checks++;
        if (n_start != s_start || n_rd != s_rd) begin
            errors++;
            $display("FAIL zero_quiet: starts=%0d reads=%0d required 0/0", n_start - s_start, n_rd - s_rd);
        end
    endtask

    task automatic test_wrap();
        int s_valid, s_rsp, s_addr;
        int exp_addr[4] = '{'h3FE, 'h3FF, 'h000, 'h001};
        for (int i = 0; i < 4; i++) begin
            ma[exp_addr[i]] = -8'sd128;
            mb[exp_addr[i]] = -8'sd128;
        end
        set_job(3, 'h3FE, 4);
        s_valid = n_valid; s_rsp = n_rsp; s_addr = addr_log.size();
        @(posedge clk); #1 req = 4'b1000;
        wait_rsp(s_rsp, 40, "wrap");
        req = '0;
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 32'd65536 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_rsp: valid=%b data=%0d err=%b required 1000/65536/0", rsp_valid, rsp_data, rsp_err);
        end
        checks++;
        if (n_valid - s_valid !== 4) begin
            errors++;
            $display("FAIL wrap_valid: got %0d required 4", n_valid - s_valid);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_log.size() <= s_addr + i || addr_log[s_addr + i] !== exp_addr[i]) begin
                errors++;
                $display("FAIL wrap_addr%0d: got %h required %h", i, addr_log.size() > s_addr + i ? addr_log[s_addr + i] : -1, exp_addr[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int s_ord;
        int exp_ord[6] = '{0, 1, 3, 0, 1, 3};
        do_reset();
        for (int i = 0; i < NREQ; i++) set_job(i, 'h20, 1);
        ma[32] = 8'sd3;
        mb[32] = 8'sd4;
        s_ord = order.size();
        @(posedge clk); #1 req = 4'b1011;
        for (int j = 0; j < 6; j++) wait_rsp(n_rsp, 30, "rr");
        req = '0;
        checks++;
        if (rsp_data !== 32'd12) begin
            errors++;
            $display("FAIL rr_data: got %0d required 12", rsp_data);
        end
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (order.size() <= s_ord + j || order[s_ord + j] !== exp_ord[j]) begin
                errors++;
                $display("FAIL rr_grant%0d: got %0d required %0d", j, order.size() > s_ord + j ? order[s_ord + j] : -1, exp_ord[j]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int s_rsp, s_start, s_valid, t;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ma[64 + i] = 8'(i + 1);
            mb[64 + i] = 8'sd1;
        end
        set_job(0, 'h40, 8);
        s_rsp = n_rsp;
        @(posedge clk); #1 req = 4'b0001;
        t = 0;
        @(negedge clk); #1;
        while (!(mem_rd_en && mem_addr == AW'('h42)) && t < 30) begin
            @(negedge clk); #1;
            t++;
        end
        checks++;
        if (t >= 30) begin
            errors++;
            $display("FAIL mid_k2: read of 0x042 never issued");
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({mem_rd_en, eng_start, eng_valid, busy, rsp_valid, rsp_err, mem_addr, eng_len, eng_a, eng_b, rsp_data} !== '0) begin
            errors++;
            $display("FAIL mid_clear: rd=%b val=%b busy=%b addr=%h a=%0d len=%0d required all 0", mem_rd_en, eng_valid, busy, mem_addr, eng_a, eng_len);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n_rsp != s_rsp) begin
            errors++;
            $display("FAIL mid_lost: got %0d responses required 0", n_rsp - s_rsp);
        end
        s_start = n_start; s_valid = n_valid;
        rstn = 1'b1;
        wait_rsp(s_rsp, 60, "mid_restart");
        req = '0;
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 32'd36 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_rsp: valid=%b data=%0d err=%b required 0001/36/0", rsp_valid, rsp_data, rsp_err);
        end
        checks++;
        if (n_start - s_start !== 1 || n_valid - s_valid !== 8) begin
            errors++;
            $display("FAIL mid_stream: starts=%0d valid=%0d required 1/8", n_start - s_start, n_valid - s_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        repeat (2) @(negedge clk);
        test_over();
        repeat (2) @(negedge clk);
        test_zero();
        repeat (2) @(negedge clk);
        test_wrap();
        repeat (2) @(negedge clk);
        test_round_robin();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
